cmul_sched_7: RTL and testbench

Shared-resource scheduler for the stage-7 FFT complex multiplier. Two butterfly lanes request complex products (a+jb)·(c+jd). The block grants them round-robin, drives the multiplier's operand and `en` inputs, and waits for the Booth core's ready. It then returns the registered 24-bit real/imag result to the winning lane with a one-cycle response pulse, and reports a timeout error if ready never arrives.

---
 rtl/cmul_sched_7.sv | 174 +++++++++++++++++
 tb/tb_cmul_sched_7.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_sched_7.sv
// Round-robin scheduler sharing one complex multiplier between two butterfly lanes.
// Grants a lane, drives operands/enable, waits for ready (or times out), returns the result.
module cmul_sched_7 #(
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [11:0] op0_a,
  input  logic [11:0] op0_b,
  input  logic [11:0] op0_c,
  input  logic [11:0] op0_d,
  input  logic [11:0] op1_a,
  input  logic [11:0] op1_b,
  input  logic [11:0] op1_c,
  input  logic [11:0] op1_d,
  output logic [1:0]  gnt,
  output logic [11:0] mul_a,
  output logic [11:0] mul_b,
  output logic [11:0] mul_c,
  output logic [11:0] mul_d,
  output logic        mul_en,
  input  logic        mul_rdy,
  input  logic [23:0] mul_re,
  input  logic [23:0] mul_im,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [23:0] rsp_re,
  output logic [23:0] rsp_im,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [11:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_c_q, mul_c_d, mul_d_q, mul_d_d;
  logic        mul_en_q, mul_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [23:0] rsp_re_q, rsp_re_d, rsp_im_q, rsp_im_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        cur_id_q, cur_id_d;
  logic        last_id_q, last_id_d;
  logic        win;

  always_comb begin
    state_d     = state_q;
    gnt_d       = 2'b00;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_c_d     = mul_c_q;
    mul_d_d     = mul_d_q;
    mul_en_d    = mul_en_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_re_d    = rsp_re_q;
    rsp_im_d    = rsp_im_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    last_id_d   = last_id_q;
    win         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the lane that did not win last time goes next.
          win       = (req == 2'b11) ? ~last_id_q : req[1];
          mul_a_d   = win ? op1_a : op0_a;
          mul_b_d   = win ? op1_b : op0_b;
          mul_c_d   = win ? op1_c : op0_c;
          mul_d_d   = win ? op1_d : op0_d;
          cur_id_d  = win;
          last_id_d = win;
          gnt_d     = win ? 2'b10 : 2'b01;
          mul_en_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        // Ready below MIN_LAT may be left over from the previous operation.
        if (mul_rdy && (cnt_q >= CW'(MIN_LAT))) begin
          rsp_re_d    = mul_re;
          rsp_im_d    = mul_im;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          mul_en_d    = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_re_d    = '0;
          rsp_im_d    = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          mul_en_d    = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_c_q     <= '0;
      mul_d_q     <= '0;
      mul_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_re_q    <= '0;
      rsp_im_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      cur_id_q    <= 1'b0;
      last_id_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_c_q     <= mul_c_d;
      mul_d_q     <= mul_d_d;
      mul_en_q    <= mul_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_re_q    <= rsp_re_d;
      rsp_im_q    <= rsp_im_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_c     = mul_c_q;
  assign mul_d     = mul_d_q;
  assign mul_en    = mul_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_re    = rsp_re_q;
  assign rsp_im    = rsp_im_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cmul_sched_7.sv
// Bench for cmul_sched_7: mock multiplier, cycle-level timing model, directed scenarios.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_cmul_sched_7;

  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [11:0] op0_a, op0_b, op0_c, op0_d, op1_a, op1_b, op1_c, op1_d;
  logic [1:0]  gnt;
  logic [11:0] mul_a, mul_b, mul_c, mul_d;
  logic        mul_en, mul_rdy;
  logic [23:0] mul_re, mul_im;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [23:0] rsp_re, rsp_im;
  logic [1:0]  state_dbg;

  cmul_sched_7 #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0_a(op0_a), .op0_b(op0_b), .op0_c(op0_c), .op0_d(op0_d),
    .op1_a(op1_a), .op1_b(op1_b), .op1_c(op1_c), .op1_d(op1_d),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_en(mul_en), .mul_rdy(mul_rdy), .mul_re(mul_re), .mul_im(mul_im),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_re(rsp_re), .rsp_im(rsp_im),
    .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference complex multiplier with a fixed >>7 scale.
  function automatic int prod_re(input int a, input int b, input int c, input int d);
    return (a * c - b * d) >>> 7;
  endfunction
  function automatic int prod_im(input int a, input int b, input int c, input int d);
    return (a * d + b * c) >>> 7;
  endfunction

  // ---------------- mock multiplier ----------------
  int rdy_k = -1;   // BUSY index at which ready rises; -1 = never
  logic stale = 1'b0;
  int bi = 0;

  assign mul_re = 24'(prod_re($signed(mul_a), $signed(mul_b), $signed(mul_c), $signed(mul_d)));
  assign mul_im = 24'(prod_im($signed(mul_a), $signed(mul_b), $signed(mul_c), $signed(mul_d)));

  always @(negedge clk) begin
    if (gnt != 2'b00) bi = -1;
    else if (mul_en) bi = bi + 1;
    mul_rdy = stale || (rdy_k >= 0 && mul_en && gnt == 2'b00 && bi >= rdy_k);
  end

  // ---------------- timing model + scoreboard ----------------
  logic run = 1'b0;
  logic m_act, m_last, m_id, m_err, m_herr;
  int   m_gcyc, m_rcyc;
  logic [11:0] p_a, p_b, p_c, p_d, m_ea, m_eb, m_ec, m_ed;
  logic [23:0] m_re, m_im, m_hre, m_him;
  logic [1:0]  e_gnt;
  logic        e_en, e_busy, e_rv, w;
  int   k, kacc;

  int   g_n = 0;
  int   g_log[16];
  int   rv_n = 0;
  int   rv_cyc, rv_id_log[16];
  logic [23:0] rv_re, rv_im;
  logic rv_id, rv_err;

  task automatic model_reset();
    m_act = 1'b0; m_last = 1'b1; m_id = 1'b0; m_err = 1'b0; m_herr = 1'b0;
    m_ea = '0; m_eb = '0; m_ec = '0; m_ed = '0;
    m_re = '0; m_im = '0; m_hre = '0; m_him = '0;
    m_gcyc = 0; m_rcyc = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && run) begin
      if (m_act && cyc == m_gcyc) begin
        m_ea = p_a; m_eb = p_b; m_ec = p_c; m_ed = p_d;
      end
      if (m_act && cyc == m_rcyc) begin
        m_hre = m_re; m_him = m_im; m_herr = m_err;
      end
      e_gnt  = (m_act && cyc == m_gcyc) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      e_en   = m_act && cyc >= m_gcyc && cyc < m_rcyc;
      e_busy = m_act && cyc >= m_gcyc;
      e_rv   = m_act && cyc == m_rcyc;
      check("gnt", gnt, e_gnt);
      check("mul_en", mul_en, e_en);
      check("busy", busy, e_busy);
      check("rsp_valid", rsp_valid, e_rv);
      check("mul_a", mul_a, m_ea);
      check("mul_b", mul_b, m_eb);
      check("mul_c", mul_c, m_ec);
      check("mul_d", mul_d, m_ed);
      check("rsp_re", rsp_re, m_hre);
      check("rsp_im", rsp_im, m_him);
      check("rsp_err", rsp_err, m_herr);
      if (e_rv) check("rsp_id", rsp_id, m_id);
      if (gnt != 2'b00 && g_n < 16) begin
        g_log[g_n] = gnt[1] ? 1 : 0;
        g_n++;
      end
      if (rsp_valid) begin
        rv_cyc = cyc; rv_re = rsp_re; rv_im = rsp_im; rv_id = rsp_id; rv_err = rsp_err;
        if (rv_n < 16) rv_id_log[rv_n] = rsp_id ? 1 : 0;
        rv_n++;
      end
      if (m_act && cyc == m_rcyc) begin
        m_act = 1'b0;
      end else if (!m_act && req != 2'b00) begin
        w = (req == 2'b11) ? ~m_last : req[1];
        m_last = w; m_id = w;
        p_a = w ? op1_a : op0_a; p_b = w ? op1_b : op0_b;
        p_c = w ? op1_c : op0_c; p_d = w ? op1_d : op0_d;
        k = stale ? 0 : rdy_k;
        if (k < 0 || k > TIMEOUT) begin
          kacc = TIMEOUT; m_err = 1'b1; m_re = '0; m_im = '0;
        end else begin
          kacc = (k < MIN_LAT) ? MIN_LAT : k;
          m_err = 1'b0;
          m_re = 24'(prod_re($signed(p_a), $signed(p_b), $signed(p_c), $signed(p_d)));
          m_im = 24'(prod_im($signed(p_a), $signed(p_b), $signed(p_c), $signed(p_d)));
        end
        m_gcyc = cyc + 1;
        m_rcyc = cyc + 3 + kacc;
        m_act  = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0; run = 1'b1;
  endtask

  task automatic set_ops(input logic lane, input int a, input int b, input int c, input int d);
    if (lane) begin
      op1_a = 12'(a); op1_b = 12'(b); op1_c = 12'(c); op1_d = 12'(d);
    end else begin
      op0_a = 12'(a); op0_b = 12'(b); op0_c = 12'(c); op0_d = 12'(d);
    end
  endtask

  // Raise req for one cycle from IDLE; t0 is the cycle whose closing edge samples it.
  task automatic issue(input logic [1:0] mask, output int t0);
    req = mask; t0 = cyc;
    tick();
    req = 2'b00;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int i;
    for (i = 0; i < budget && rv_n < target; i++) tick();
    if (rv_n < target) check("rsp_wait_expired", 32'(rv_n), 32'(target));
  endtask

  // ---------------- directed scenarios ----------------
  int t0, base, got;

  initial begin
    rst = 1'b1; req = 2'b00;
    set_ops(1'b0, 0, 0, 0, 0);
    set_ops(1'b1, 0, 0, 0, 0);
    model_reset();
    repeat (2) tick();
    check("rst_gnt", gnt, 2'b00);
    check("rst_mul_en", mul_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_mul_a", mul_a, 12'd0);
    check("rst_rsp_re", rsp_re, 24'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rst = 1'b0; run = 1'b1;
    tick();

    // Single lane 0 op, ready at busy_cnt=3.
    set_ops(1'b0, 100, 0, 256, 0);
    rdy_k = 3; base = rv_n;
    req = 2'b01; t0 = cyc;
    tick();
    check("t1_gnt", gnt, 2'b01);
    req = 2'b00;
    wait_rsp(base + 1, 40);
    check("t1_lat", 32'(rv_cyc - t0), 32'd6);
    check("t1_re", rv_re, 24'd200);
    check("t1_im", rv_im, 24'd0);
    check("t1_id", rv_id, 1'b0);
    check("t1_err", rv_err, 1'b0);

    // Both lanes continuously requesting: grants alternate from a fresh reset.
    do_reset();
    set_ops(1'b0, -300, 50, 1000, -20);
    set_ops(1'b1, 77, -88, -512, 300);
    rdy_k = 4; g_n = 0; base = rv_n; got = 0;
    req = 2'b11;
    for (int i = 0; i < 200 && got < 4; i++) begin
      tick();
      if (gnt != 2'b00) got++;
    end
    req = 2'b00;
    wait_rsp(base + 4, 100);
    check("rr_g0", 32'(g_log[0]), 32'd0);
    check("rr_g1", 32'(g_log[1]), 32'd1);
    check("rr_g2", 32'(g_log[2]), 32'd0);
    check("rr_g3", 32'(g_log[3]), 32'd1);
    for (int i = 0; i < 4; i++)
      check("rr_rsp_id", 32'(rv_id_log[base + i]), 32'(g_log[i]));

    // Stale ready held high from reset: accepted at busy_cnt=MIN_LAT.
    stale = 1'b1;
    do_reset();
    set_ops(1'b1, 640, -640, 128, 128);
    base = rv_n;
    issue(2'b10, t0);
    wait_rsp(base + 1, 40);
    check("stale_lat", 32'(rv_cyc - t0), 32'd5);
    check("stale_re", rv_re, 24'd1280);
    check("stale_im", rv_im, 24'd0);
    stale = 1'b0;
    tick();

    // Ready never arrives: timeout error with zeroed result.
    rdy_k = -1; base = rv_n;
    set_ops(1'b0, 10, 20, 30, 40);
    issue(2'b01, t0);
    wait_rsp(base + 1, 100);
    check("to_lat", 32'(rv_cyc - t0), 32'd66);
    check("to_err", rv_err, 1'b1);
    check("to_re", rv_re, 24'd0);
    check("to_im", rv_im, 24'd0);

    // Ready rises exactly at busy_cnt=TIMEOUT: ready wins.
    rdy_k = TIMEOUT; base = rv_n;
    set_ops(1'b1, 256, 128, 256, -128);
    issue(2'b10, t0);
    wait_rsp(base + 1, 100);
    check("rdy_to_lat", 32'(rv_cyc - t0), 32'd66);
    check("rdy_to_err", rv_err, 1'b0);
    check("rdy_to_re", rv_re, 24'd640);
    check("rdy_to_im", rv_im, 24'd0);

    // Reset during BUSY: outputs clear immediately, no response, then lane 1 runs normally.
    rdy_k = -1; base = rv_n;
    set_ops(1'b0, 5, 6, 7, 8);
    issue(2'b01, t0);
    repeat (5) tick();
    rst = 1'b1; run = 1'b0;
    #1;
    check("mid_rst_mul_en", mul_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_mul_a", mul_a, 12'd0);
    check("mid_rst_rsp_re", rsp_re, 24'd0);
    check("mid_rst_state", state_dbg, 2'd0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0; run = 1'b1;
    tick();
    check("mid_rst_no_rsp", 32'(rv_n), 32'(base));
    rdy_k = 2;
    set_ops(1'b1, -128, 0, 128, 0);
    req = 2'b10; t0 = cyc;
    tick();
    check("post_rst_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_rsp(base + 1, 40);
    check("post_rst_lat", 32'(rv_cyc - t0), 32'd5);
    check("post_rst_id", rv_id, 1'b1);
    check("post_rst_re", rv_re, 24'hFFFF80);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
